// File: rtl/fifo_dc_pkg.sv
// Shared constants and types for the dual-clock generic FIFO and its read-side stream engine.
package fifo_dc_pkg;

    localparam int DW         = 8;
    localparam int AW         = 4;
    localparam int SKID_DEPTH = 2;

    typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: head at entry 0, pop shifts before the captured word lands.
module fifo_rd_skid #(
    parameter int DW = fifo_dc_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic          valid,
    output logic [DW-1:0] dout
);
    import fifo_dc_pkg::*;

    logic [1:0]    occ_pop;
    logic [1:0]    occ_nxt;
    logic [DW-1:0] ent0;
    logic [DW-1:0] ent1;
    logic [DW-1:0] ent0_nxt;
    logic [DW-1:0] ent1_nxt;

    // The word arriving with a simultaneous pop at occ=1 lands directly in the head slot.
    always_comb begin
        occ_pop  = occ - {1'b0, pop};
        occ_nxt  = occ_pop + {1'b0, push};
        ent0_nxt = pop ? ent1 : ent0;
        ent1_nxt = ent1;
        if (push) begin
            if (occ_pop == 2'd0) begin
                ent0_nxt = din;
            end else begin
                ent1_nxt = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (clr) begin
            occ  <= 2'd0;
        end else begin
            occ  <= occ_nxt;
            ent0 <= ent0_nxt;
            ent1 <= ent1_nxt;
        end
    end

    assign valid = (occ != 2'd0);
    assign dout  = ent0;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain engine presenting words as a valid/ready stream.
// Optional m_last burst marker enabled by defining FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream #(
    parameter int DW        = fifo_dc_pkg::DW,
    parameter int CNT_W     = 16,
    parameter int BURST_LEN = 16
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_dout,
    output logic             fifo_re,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    input  logic             m_ready,
`ifdef FIFO_RD_STREAM_LAST_EN
    output logic             m_last,
`endif
    output logic [CNT_W-1:0] rd_count
);
    import fifo_dc_pkg::*;

    if (BURST_LEN < 1) begin : g_bad_burst
        $error("BURST_LEN must be at least 1");
    end

    logic       inflight_p1;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] demand;

    assign pop    = m_valid & m_ready;
    // Entries held plus the word already requested, less the one leaving now.
    assign demand = {1'b0, occ} + {2'b0, inflight_p1} - {2'b0, pop};
    assign fifo_re = ~fifo_empty & ~clr & (demand < 3'(SKID_DEPTH));

    fifo_rd_skid #(
        .DW (DW)
    ) u_skid (
        .clk   (rd_clk),
        .rst   (rst),
        .clr   (clr),
        .push  (inflight_p1),
        .din   (fifo_dout),
        .pop   (pop),
        .occ   (occ),
        .valid (m_valid),
        .dout  (m_data)
    );

    // Read request stage: fifo_dout is valid the cycle after fifo_re.
    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            inflight_p1 <= 1'b0;
            rd_count    <= '0;
        end else if (clr) begin
            inflight_p1 <= 1'b0;
            rd_count    <= '0;
        end else begin
            inflight_p1 <= fifo_re;
            if (pop) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    logic [BEAT_W-1:0] beat;

    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (pop) begin
            beat <= (beat == BEAT_MAX) ? '0 : beat + 1'b1;
        end
    end

    assign m_last = m_valid & (beat == BEAT_MAX);
`endif

endmodule
